// File: rtl/bcd2bin.sv
// bcd2bin: converts a signed 4-digit BCD word into an 11-bit two's-complement
// value. One digit is folded in per cycle (acc = acc*10 + digit) using only
// shifts and adds. The latency is fixed and does not depend on the data:
// the error path takes exactly as long as a good word.
module bcd2bin (
    input  logic        clk,
    input  logic        rst,
    input  logic        bcd_vld,
    input  logic [16:0] bcd,
    output logic        bcd_rdy,
    output logic [10:0] bin,
    output logic        bin_err,
    output logic        bin_vld,
    input  logic        bin_rdy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CHK  = 3'd1,
        ACC  = 3'd2,
        SGN  = 3'd3,
        OUT  = 3'd4
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic [16:0] bcd_reg;      // captured input word
    logic [14:0] acc_reg;      // 15 bits: holds up to 16665 (all digits = 15)
    logic [1:0]  cnt_reg;      // digits already folded into acc_reg
    logic        err_reg;      // malformed or out-of-range flag
    logic [10:0] bin_reg;
    logic        bin_err_reg;

    // Per-digit view of the captured word, ones digit at index 0.
    logic [3:0]  digit     [4];
    logic [3:0]  digit_bad;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            assign digit[gi]     = bcd_reg[4*gi +: 4];
            assign digit_bad[gi] = (digit[gi] > 4'd9);
        end
    endgenerate

    // The most significant digit is processed first, so the index counts down.
    logic [1:0]  digit_sel;
    logic [3:0]  cur_digit;
    logic [14:0] acc_next;
    logic        sgn_err;
    logic [10:0] sgn_bin;

    assign digit_sel = 2'd3 - cnt_reg;
    assign cur_digit = digit[digit_sel];
    assign acc_next  = (acc_reg << 3) + (acc_reg << 1) + {11'd0, cur_digit};

    // The final error decision adds the magnitude check to the digit check.
    // Negative zero needs no special case: ~0 + 1 wraps back to 0.
    assign sgn_err = err_reg | (acc_reg > 15'd1023);
    assign sgn_bin = sgn_err    ? 11'd0 :
                     bcd_reg[16] ? (~acc_reg[10:0] + 11'd1) : acc_reg[10:0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: CHK and SGN are one cycle each, ACC runs for 4 digits.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bcd_vld) state_next = CHK;
            CHK:     state_next = ACC;
            ACC:     if (cnt_reg == 2'd3) state_next = SGN;
            SGN:     state_next = OUT;
            OUT:     if (bin_rdy) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture, check, accumulate, then sign-apply into the output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_reg     <= 17'd0;
            acc_reg     <= 15'd0;
            cnt_reg     <= 2'd0;
            err_reg     <= 1'b0;
            bin_reg     <= 11'd0;
            bin_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bcd_vld) bcd_reg <= bcd;
                end
                CHK: begin
                    acc_reg <= 15'd0;
                    cnt_reg <= 2'd0;
                    err_reg <= (|digit_bad) | (|bcd_reg[15:13]);
                end
                ACC: begin
                    acc_reg <= acc_next;
                    cnt_reg <= cnt_reg + 2'd1;
                end
                SGN: begin
                    err_reg     <= sgn_err;
                    bin_err_reg <= sgn_err;
                    bin_reg     <= sgn_bin;
                end
                default: ;
            endcase
        end
    end

    assign bcd_rdy = (state_reg == IDLE);
    assign bin_vld = (state_reg == OUT);
    assign bin     = bin_reg;
    assign bin_err = bin_err_reg;

endmodule

// File: tb/tb_bcd2bin.sv
// Bench for bcd2bin: directed table, randomized words against an arithmetic
// reference, and hand-written backpressure, reset and streaming sequences.
module tb_bcd2bin;

    logic        clk = 1'b0;
    logic        rst;
    logic        bcd_vld;
    logic [16:0] bcd;
    logic        bcd_rdy;
    logic [10:0] bin;
    logic        bin_err;
    logic        bin_vld;
    logic        bin_rdy;

    int total = 0;
    int bad   = 0;

    bcd2bin dut (
        .clk     (clk),
        .rst     (rst),
        .bcd_vld (bcd_vld),
        .bcd     (bcd),
        .bcd_rdy (bcd_rdy),
        .bin     (bin),
        .bin_err (bin_err),
        .bin_vld (bin_vld),
        .bin_rdy (bin_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] w;
        logic [10:0] eb;
        logic        ee;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: decimal value from the digits, error if any digit is not
    // decimal or the magnitude exceeds 1023; returns {err, bin}.
    function automatic logic [11:0] model(input logic [16:0] w);
        int         d [4];
        int         val;
        logic       err;
        logic [10:0] b;
        for (int i = 0; i < 4; i++) d[i] = int'((w >> (4*i)) & 17'hF);
        val = d[3]*1000 + d[2]*100 + d[1]*10 + d[0];
        err = (val > 1023);
        for (int i = 0; i < 4; i++) if (d[i] > 9) err = 1'b1;
        if (err)        b = 11'd0;
        else if (w[16]) b = 11'(-val);
        else            b = 11'(val);
        return {err, b};
    endfunction

    // One full transaction with bin_rdy high: accept, 6-cycle latency, 1-cycle result.
    task automatic run_word(input logic [16:0] w, input logic [10:0] eb, input logic ee,
                            input string tag);
        int n;
        n = 0;
        while (!bcd_rdy && n < 20) begin step(); n++; end
        chk({tag, " rdy"}, 32'(bcd_rdy), 32'd1);
        bcd     = w;
        bcd_vld = 1'b1;
        step();
        bcd_vld = 1'b0;
        n = 0;
        while (!bin_vld && n < 20) begin step(); n++; end
        $display("word %05h -> bin %03h err %0b latency %0d", w, bin, bin_err, n);
        chk({tag, " latency"}, 32'(n), 32'd6);
        chk({tag, " bin"}, 32'(bin), 32'(eb));
        chk({tag, " err"}, 32'(bin_err), 32'(ee));
        step();
        chk({tag, " vld_pulse"}, 32'(bin_vld), 32'd0);
        chk({tag, " rdy_after"}, 32'(bcd_rdy), 32'd1);
    endtask

    vec_t        tbl [8];
    logic [16:0] rw;
    logic [11:0] em;
    logic [16:0] bw [4];
    int          acc_cyc [$];
    int          n, cyc, idx, got, last;
    logic        seen, take;

    initial begin
        tbl[0] = '{17'h01023, 11'h3FF, 1'b0};
        tbl[1] = '{17'h11023, 11'h401, 1'b0};
        tbl[2] = '{17'h10000, 11'h000, 1'b0};
        tbl[3] = '{17'h00999, 11'h3E7, 1'b0};
        tbl[4] = '{17'h01024, 11'h000, 1'b1};
        tbl[5] = '{17'h00A00, 11'h000, 1'b1};
        tbl[6] = '{17'h0E000, 11'h000, 1'b1};
        tbl[7] = '{17'h00000, 11'h000, 1'b0};

        // Reset, with a word offered during reset that must not be taken.
        rst     = 1'b1;
        bcd_vld = 1'b1;
        bcd     = 17'h00042;
        bin_rdy = 1'b1;
        step();
        step();
        rst     = 1'b0;
        bcd_vld = 1'b0;
        chk("reset bcd_rdy", 32'(bcd_rdy), 32'd1);
        chk("reset bin", 32'(bin), 32'd0);
        chk("reset bin_err", 32'(bin_err), 32'd0);
        chk("reset bin_vld", 32'(bin_vld), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin step(); if (bin_vld) seen = 1'b1; end
        chk("reset no_accept", 32'(seen), 32'd0);

        // Directed table.
        for (int i = 0; i < 8; i++) run_word(tbl[i].w, tbl[i].eb, tbl[i].ee, $sformatf("tbl%0d", i));

        // Randomized words, mostly legal, some arbitrary.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) != 0)
                rw = {1'($urandom_range(0, 1)), 3'b000, 4'($urandom_range(0, 1)),
                      4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            else
                rw = 17'($urandom);
            em = model(rw);
            run_word(rw, em[10:0], em[11], $sformatf("rnd%0d", i));
        end

        // Backpressure: hold the result for 3 cycles, offer a word meanwhile.
        bin_rdy = 1'b0;
        bcd     = 17'h10500;
        bcd_vld = 1'b1;
        step();
        bcd_vld = 1'b0;
        n = 0;
        while (!bin_vld && n < 20) begin step(); n++; end
        chk("bp latency", 32'(n), 32'd6);
        for (int k = 0; k < 3; k++) begin
            bcd_vld = (k == 1);
            bcd     = 17'h00007;
            step();
            $display("backpressure cycle %0d bin %03h err %0b vld %0b rdy %0b", k, bin, bin_err, bin_vld, bcd_rdy);
            chk("bp bin", 32'(bin), 32'h60C);
            chk("bp err", 32'(bin_err), 32'd0);
            chk("bp vld", 32'(bin_vld), 32'd1);
            chk("bp bcd_rdy", 32'(bcd_rdy), 32'd0);
        end
        bcd_vld = 1'b0;
        bin_rdy = 1'b1;
        step();
        chk("bp release vld", 32'(bin_vld), 32'd0);
        chk("bp release rdy", 32'(bcd_rdy), 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin step(); if (bin_vld) seen = 1'b1; end
        chk("bp pulse ignored", 32'(seen), 32'd0);

        // Reset during the second accumulate cycle.
        bcd     = 17'h00999;
        bcd_vld = 1'b1;
        step();
        bcd_vld = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst bcd_rdy", 32'(bcd_rdy), 32'd1);
        chk("midrst bin_vld", 32'(bin_vld), 32'd0);
        chk("midrst bin", 32'(bin), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin step(); if (bin_vld) seen = 1'b1; end
        chk("midrst no result", 32'(seen), 32'd0);
        run_word(17'h00042, 11'h02A, 1'b0, "after_rst");

        // Back-to-back: bcd_vld held high across 4 words.
        bw[0] = 17'h00001;
        bw[1] = 17'h10123;
        bw[2] = 17'h00A01;
        bw[3] = 17'h01000;
        idx = 0; cyc = 0; got = 0; last = 0;
        bcd     = bw[0];
        bcd_vld = 1'b1;
        for (int c = 0; c < 60 && got < 4; c++) begin
            take = bcd_vld && bcd_rdy;
            step();
            cyc++;
            if (take) begin
                acc_cyc.push_back(cyc);
                idx++;
                if (idx < 4) bcd = bw[idx];
                else bcd_vld = 1'b0;
            end
            if (bin_vld) begin
                em = model(bw[got]);
                $display("stream result %0d bin %03h err %0b cycle %0d", got, bin, bin_err, cyc);
                chk($sformatf("b2b%0d bin", got), 32'(bin), 32'(em[10:0]));
                chk($sformatf("b2b%0d err", got), 32'(bin_err), 32'(em[11]));
                if (got < acc_cyc.size())
                    chk($sformatf("b2b%0d latency", got), 32'(cyc - acc_cyc[got]), 32'd6);
                if (got > 0)
                    chk($sformatf("b2b%0d spacing", got), 32'(cyc - last), 32'd8);
                last = cyc;
                got++;
            end
        end
        bcd_vld = 1'b0;
        chk("b2b count", 32'(got), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
